// File: rtl/wb_arb_pkg.sv
// Shared CPU writeback definitions.
// Holds the default data width, register count and register index width, plus the
// {rd, data} writeback entry carried by the ALU FIFO and the output register.
package wb_arb_pkg;

    localparam int unsigned D_WIDTH = 32;
    localparam int unsigned N_REGS  = 32;
    localparam int unsigned REG_L2  = $clog2(N_REGS);

    typedef struct packed {
        logic [REG_L2-1:0]  rd;
        logic [D_WIDTH-1:0] data;
    } wb_entry;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO for buffered ALU writeback results.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write an entry (caller guarantees count < 2)
//   pop             drop the head entry (caller guarantees count > 0)
//   head            oldest entry, valid when count != 0
//   count           number of held entries, 0..2
// Push and pop in the same cycle leave count unchanged.
module wb_fifo2
    import wb_arb_pkg::*;
#(
    parameter type entry_t = wb_entry
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     din,
    input  logic       pop,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter in front of the register file's single write port.
// Load results win; ALU results bypass when nothing else is pending, otherwise queue
// in a 2-entry FIFO. A per-register scoreboard tracks outstanding loads.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   ld_valid/ld_rd/ld_data         load result, always accepted
//   ld_issue/ld_issue_rd           load issue, marks the destination busy
//   we/w_addr/w_data               registered register-file write
//   sb_busy                        registered outstanding-load scoreboard
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned D_WIDTH = wb_arb_pkg::D_WIDTH,
    parameter int unsigned N_REGS  = wb_arb_pkg::N_REGS,
    parameter int unsigned REG_L2  = $clog2(N_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [REG_L2-1:0]  alu_rd,
    input  logic [D_WIDTH-1:0] alu_data,
    input  logic               ld_valid,
    input  logic [REG_L2-1:0]  ld_rd,
    input  logic [D_WIDTH-1:0] ld_data,
    input  logic               ld_issue,
    input  logic [REG_L2-1:0]  ld_issue_rd,
    output logic               we,
    output logic [REG_L2-1:0]  w_addr,
    output logic [D_WIDTH-1:0] w_data,
    output logic [N_REGS-1:0]  sb_busy
);

    typedef struct packed {
        logic [REG_L2-1:0]  rd;
        logic [D_WIDTH-1:0] data;
    } entry_t;

    entry_t             fifo_head;
    entry_t             alu_entry;
    entry_t             sel;
    logic [1:0]         fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               alu_accept;
    logic               sel_valid;
    logic               we_d;
    logic               we_q;
    logic [REG_L2-1:0]  w_addr_q;
    logic [D_WIDTH-1:0] w_data_q;
    logic [N_REGS-1:0]  sb_d;
    logic [N_REGS-1:0]  sb_q;

    // Depends on FIFO occupancy only, so the ALU never sees a load-dependent ready.
    assign alu_ready  = (fifo_count < 2'd2);
    assign alu_accept = alu_valid && alu_ready;
    assign alu_entry  = '{rd: alu_rd, data: alu_data};

    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        if (ld_valid) begin
            sel       = '{rd: ld_rd, data: ld_data};
            sel_valid = 1'b1;
            fifo_push = alu_accept;
        end else if (fifo_count != 2'd0) begin
            sel       = fifo_head;
            sel_valid = 1'b1;
            fifo_pop  = 1'b1;
            fifo_push = alu_accept;
        end else if (alu_accept) begin
            sel       = alu_entry;
            sel_valid = 1'b1;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    assign we_d = sel_valid && (sel.rd != '0);

    always_comb begin
        sb_d = sb_q;
        if (ld_valid) begin
            sb_d[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            sb_d[ld_issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    wb_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (alu_entry),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            sb_q     <= '0;
        end else begin
            we_q <= we_d;
            if (we_d) begin
                w_addr_q <= sel.rd;
                w_data_q <= sel.data;
            end
            sb_q <= sb_d;
        end
    end

    assign we      = we_q;
    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;
    assign sb_busy = sb_q;

endmodule

// File: tb/tb_wb_arb.sv
// Directed self-checking bench for wb_arb.
module tb_wb_arb;

    localparam int D_WIDTH = 32;
    localparam int N_REGS  = 32;
    localparam int REG_L2  = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               alu_valid;
    logic               alu_ready;
    logic [REG_L2-1:0]  alu_rd;
    logic [D_WIDTH-1:0] alu_data;
    logic               ld_valid;
    logic [REG_L2-1:0]  ld_rd;
    logic [D_WIDTH-1:0] ld_data;
    logic               ld_issue;
    logic [REG_L2-1:0]  ld_issue_rd;
    logic               we;
    logic [REG_L2-1:0]  w_addr;
    logic [D_WIDTH-1:0] w_data;
    logic [N_REGS-1:0]  sb_busy;

    int checks = 0;
    int errors = 0;

    wb_arb #(
        .D_WIDTH (D_WIDTH),
        .N_REGS  (N_REGS),
        .REG_L2  (REG_L2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .we          (we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .sb_busy     (sb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [REG_L2-1:0] a,
                          input logic [D_WIDTH-1:0] d);
        chk({tag, ".we"}, 64'(we), 64'd1);
        chk({tag, ".addr"}, 64'(w_addr), 64'(a));
        chk({tag, ".data"}, 64'(w_data), 64'(d));
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
        ld_issue    = 1'b0;
        ld_issue_rd = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_ready_async", 64'(alu_ready), 64'd1);
        tick();
        tick();
        // Reset state
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_waddr", 64'(w_addr), 64'd0);
        chk("rst_wdata", 64'(w_data), 64'd0);
        chk("rst_sb", 64'(sb_busy), 64'd0);
        chk("rst_ready", 64'(alu_ready), 64'd1);
        rst = 1'b0;
        tick();
        chk("idle_we", 64'(we), 64'd0);

        // Single ALU result via bypass
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        chk("single_ready", 64'(alu_ready), 64'd1);
        tick();
        idle_inputs();
        chk_wr("single", 5'd5, 32'hDEAD_BEEF);
        tick();
        chk("single_we_off", 64'(we), 64'd0);
        chk("single_hold_addr", 64'(w_addr), 64'd5);
        chk("single_hold_data", 64'(w_data), 64'hDEAD_BEEF);

        // Collision: load first, ALU next cycle
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h22;
        tick();
        idle_inputs();
        chk_wr("coll_ld", 5'd4, 32'h22);
        tick();
        chk_wr("coll_alu", 5'd3, 32'h11);
        tick();
        chk("coll_we_off", 64'(we), 64'd0);

        // Backpressure: 4-cycle load burst while ALU offers rd=1,2,3
        ld_valid = 1'b1; ld_rd = 5'd10;
        ld_data = 32'h100; alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        chk("bp_ready_c1", 64'(alu_ready), 64'd1);
        tick();
        chk_wr("bp_ld1", 5'd10, 32'h100);
        ld_data = 32'h101; alu_rd = 5'd2; alu_data = 32'hA2;
        chk("bp_ready_c2", 64'(alu_ready), 64'd1);
        tick();
        chk_wr("bp_ld2", 5'd10, 32'h101);
        ld_data = 32'h102; alu_rd = 5'd3; alu_data = 32'hA3;
        chk("bp_ready_c3", 64'(alu_ready), 64'd0);
        tick();
        chk_wr("bp_ld3", 5'd10, 32'h102);
        ld_data = 32'h103;
        chk("bp_ready_c4", 64'(alu_ready), 64'd0);
        tick();
        chk_wr("bp_ld4", 5'd10, 32'h103);
        ld_valid = 1'b0;
        chk("bp_ready_c5", 64'(alu_ready), 64'd0);
        tick();
        chk_wr("bp_alu1", 5'd1, 32'hA1);
        chk("bp_ready_c6", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        chk_wr("bp_alu2", 5'd2, 32'hA2);
        tick();
        chk_wr("bp_alu3", 5'd3, 32'hA3);
        tick();
        chk("bp_we_off", 64'(we), 64'd0);
        chk("bp_ready_end", 64'(alu_ready), 64'd1);

        // x0 suppression
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        tick();
        idle_inputs();
        chk("x0_we", 64'(we), 64'd0);
        chk("x0_hold_addr", 64'(w_addr), 64'd3);
        chk("x0_hold_data", 64'(w_data), 64'hA3);
        chk("x0_sb", 64'(sb_busy), 64'd0);
        tick();
        chk("x0_no_late_write", 64'(we), 64'd0);

        // Scoreboard set, set-wins-over-clear, then clear
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle_inputs();
        chk("sb_set", 64'(sb_busy), 64'h80);
        tick(); tick(); tick();
        chk("sb_held", 64'(sb_busy), 64'h80);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle_inputs();
        chk("sb_set_wins", 64'(sb_busy), 64'h80);
        chk_wr("sb_ld1", 5'd7, 32'h77);
        tick(); tick();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
        tick();
        idle_inputs();
        chk("sb_clear", 64'(sb_busy), 64'd0);
        chk_wr("sb_ld2", 5'd7, 32'h78);
        tick();

        // Reset mid-flight with FIFO full and a busy scoreboard bit
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        idle_inputs();
        ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hB0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
        tick();
        alu_rd = 5'd13; alu_data = 32'hC1;
        tick();
        idle_inputs();
        chk("mid_full", 64'(alu_ready), 64'd0);
        chk("mid_sb", 64'(sb_busy), 64'h200);
        chk_wr("mid_ld", 5'd11, 32'hB0);
        rst = 1'b1;
        #1;
        chk("mrst_we", 64'(we), 64'd0);
        chk("mrst_addr", 64'(w_addr), 64'd0);
        chk("mrst_data", 64'(w_data), 64'd0);
        chk("mrst_sb", 64'(sb_busy), 64'd0);
        chk("mrst_ready", 64'(alu_ready), 64'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_we%0d", i), 64'(we), 64'd0);
        end
        chk("post_rst_sb", 64'(sb_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
